// File: rtl/gfx_pkg.sv
// Shared types and widths for the overlay compositor.
//   COLOR_W       : RGB888 pixel width
//   CH_W          : width of one colour channel
//   NUM_CH        : channels per pixel
//   screen_mode_t : frame-level screen mode (PLAY, FLASH, FADE, OVER)
package gfx_pkg;

  localparam int COLOR_W = 24;
  localparam int CH_W    = 8;
  localparam int NUM_CH  = COLOR_W / CH_W;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    FLASH = 2'd1,
    FADE  = 2'd2,
    OVER  = 2'd3
  } screen_mode_t;

endpackage

// File: rtl/overlay_compositor_if.sv
// Pixel-stream bundle between the video source / game logic and the compositor.
//   master : source side, drives raster position, video, layers and game sideband
//   slave  : compositor side, returns composited pixel, delayed raster and mode
interface overlay_compositor_if #(
  parameter int NUM_LAYERS = 4
);
  import gfx_pkg::*;

  logic [10:0]                   hcount_in;
  logic [9:0]                    vcount_in;
  logic [COLOR_W-1:0]            pixel_in;
  logic [NUM_LAYERS-1:0]         layer_valid_in;
  logic [COLOR_W*NUM_LAYERS-1:0] layer_pixel_in;
  logic                          collision_in;
  logic                          game_over_in;
  logic [COLOR_W-1:0]            game_over_pixel_in;

  logic [COLOR_W-1:0]            pixel_out;
  logic [10:0]                   hcount_out;
  logic [9:0]                    vcount_out;
  logic [1:0]                    mode_out;

  modport master (
    output hcount_in, vcount_in, pixel_in, layer_valid_in, layer_pixel_in,
           collision_in, game_over_in, game_over_pixel_in,
    input  pixel_out, hcount_out, vcount_out, mode_out
  );

  modport slave (
    input  hcount_in, vcount_in, pixel_in, layer_valid_in, layer_pixel_in,
           collision_in, game_over_in, game_over_pixel_in,
    output pixel_out, hcount_out, vcount_out, mode_out
  );

endinterface

// File: rtl/overlay_compositor_alpha_blend.sv
// Stage 2 of the compositor: registered per-channel blend of the game-over
// sprite over the stage-1 composite, with blanking.
//   clk_i, rst_i : pixel clock, synchronous active-high reset
//   comp_i       : stage-1 composite pixel
//   go_i         : game-over sprite pixel
//   alpha_i      : sprite weight, 0 .. 2^FADE_LOG2 (0 = comp only, max = sprite only)
//   blank_i      : force the output pixel to black
//   pixel_o      : registered output pixel
module alpha_blend
  import gfx_pkg::*;
#(
  parameter int FADE_LOG2 = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [COLOR_W-1:0] comp_i,
  input  logic [COLOR_W-1:0] go_i,
  input  logic [FADE_LOG2:0] alpha_i,
  input  logic               blank_i,
  output logic [COLOR_W-1:0] pixel_o
);

  localparam int ACC_W = CH_W + FADE_LOG2 + 1;
  localparam logic [FADE_LOG2:0] ALPHA_MAX = (FADE_LOG2 + 1)'(1 << FADE_LOG2);

  logic [FADE_LOG2:0]  inv_alpha;
  logic [COLOR_W-1:0]  pixel_d;
  logic [COLOR_W-1:0]  pixel_q;
  logic [COLOR_W-1:0]  blend;

  assign inv_alpha = ALPHA_MAX - alpha_i;

  // The two weights sum to 2^FADE_LOG2, so the shifted sum never exceeds 8 bits.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [ACC_W-1:0] acc;
    assign acc = ACC_W'(go_i[c*CH_W +: CH_W])   * ACC_W'(alpha_i)
               + ACC_W'(comp_i[c*CH_W +: CH_W]) * ACC_W'(inv_alpha);
    assign blend[c*CH_W +: CH_W] = acc[FADE_LOG2 +: CH_W];
  end

  assign pixel_d = blank_i ? '0 : blend;

  always_ff @(posedge clk_i) begin
    if (rst_i) pixel_q <= '0;
    else       pixel_q <= pixel_d;
  end

  assign pixel_o = pixel_q;

endmodule

// File: rtl/overlay_compositor.sv
// Two-stage overlay compositor with a frame-synchronous screen-mode FSM.
//   clk_in : pixel clock
//   rst_in : synchronous active-high reset
//   bus    : slave side of overlay_compositor_if (raster, video, layers,
//            collision / game-over sideband in; pixel, delayed raster, mode out)
//
// State  | meaning
// -------+------------------------------------------------------------
// PLAY   | normal compositing of layers over video
// FLASH  | collision flash, video replaced by flash colour on odd flash_cnt
// FADE   | game-over sprite fading in, alpha steps once per frame
// OVER   | game-over sprite shown in full until game_over_in drops
module overlay_compositor
  import gfx_pkg::*;
#(
  parameter int                 ACTIVE_H_PIXELS = 1280,
  parameter int                 ACTIVE_LINES    = 720,
  parameter int                 NUM_LAYERS      = 4,
  parameter logic [COLOR_W-1:0] COLLISION_COLOR = 24'h800000,
  parameter int                 FLASH_FRAMES    = 8,
  parameter int                 FADE_LOG2       = 4
) (
  input logic                 clk_in,
  input logic                 rst_in,
  overlay_compositor_if.slave bus
);

  localparam logic [FADE_LOG2:0] ALPHA_ONE  = (FADE_LOG2 + 1)'(1);
  localparam logic [FADE_LOG2:0] ALPHA_MAX  = (FADE_LOG2 + 1)'(1 << FADE_LOG2);
  localparam logic [7:0]         FLASH_INIT = 8'(FLASH_FRAMES);
  localparam logic [10:0]        H_LIMIT    = 11'(ACTIVE_H_PIXELS);
  localparam logic [9:0]         V_LIMIT    = 10'(ACTIVE_LINES);

  screen_mode_t       mode_q, mode_d;
  logic [FADE_LOG2:0] alpha_q, alpha_d;
  logic [7:0]         flash_cnt_q, flash_cnt_d;
  logic               seen_q, seen_d;
  logic               fs;

  logic [COLOR_W-1:0] comp_d, comp_q;
  logic [COLOR_W-1:0] go_q;
  logic [FADE_LOG2:0] blend_alpha_d, blend_alpha_q;
  logic [10:0]        hcount_q;
  logic [9:0]         vcount_q;
  logic [10:0]        hcount_out_q;
  logic [9:0]         vcount_out_q;
  logic               blank;
  logic [COLOR_W-1:0] pixel_w;

  assign fs = (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mode_q      <= PLAY;
      alpha_q     <= '0;
      flash_cnt_q <= '0;
      seen_q      <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      alpha_q     <= alpha_d;
      flash_cnt_q <= flash_cnt_d;
      seen_q      <= seen_d;
    end
  end

  // The flag seen on FS belongs to the frame just ended; a collision on the
  // FS cycle itself starts the new frame's flag.
  always_comb begin
    mode_d      = mode_q;
    alpha_d     = alpha_q;
    flash_cnt_d = flash_cnt_q;
    seen_d      = seen_q | bus.collision_in;
    if (fs) begin
      seen_d = bus.collision_in;
      if (bus.game_over_in && (mode_q == PLAY || mode_q == FLASH)) begin
        mode_d  = FADE;
        alpha_d = '0;
        seen_d  = 1'b0;
      end else if (mode_q == FADE) begin
        alpha_d = alpha_q + ALPHA_ONE;
        if (alpha_d == ALPHA_MAX) mode_d = OVER;
      end else if (mode_q == OVER) begin
        if (!bus.game_over_in) mode_d = PLAY;
      end else if (mode_q == PLAY) begin
        if (seen_q) begin
          mode_d      = FLASH;
          flash_cnt_d = FLASH_INIT;
        end
      end else begin
        if (seen_q) begin
          flash_cnt_d = FLASH_INIT;
        end else begin
          flash_cnt_d = flash_cnt_q - 8'd1;
          if (flash_cnt_d == 8'd0) mode_d = PLAY;
        end
      end
    end
  end

  // Stage 1 uses the next-state values so the FS pixel already sees the new mode.
  // Scanning from the top index down leaves the lowest valid index in comp_d.
  always_comb begin
    comp_d = bus.pixel_in;
    if (mode_d == FLASH && flash_cnt_d[0]) comp_d = COLLISION_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (bus.layer_valid_in[i]) comp_d = bus.layer_pixel_in[i*COLOR_W +: COLOR_W];
    end
  end

  always_comb begin
    blend_alpha_d = '0;
    case (mode_d)
      FADE:    blend_alpha_d = alpha_d;
      OVER:    blend_alpha_d = ALPHA_MAX;
      default: blend_alpha_d = '0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      comp_q        <= '0;
      go_q          <= '0;
      blend_alpha_q <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      hcount_out_q  <= '0;
      vcount_out_q  <= '0;
    end else begin
      comp_q        <= comp_d;
      go_q          <= bus.game_over_pixel_in;
      blend_alpha_q <= blend_alpha_d;
      hcount_q      <= bus.hcount_in;
      vcount_q      <= bus.vcount_in;
      hcount_out_q  <= hcount_q;
      vcount_out_q  <= vcount_q;
    end
  end

  assign blank = (hcount_q >= H_LIMIT) || (vcount_q >= V_LIMIT);

  alpha_blend #(
    .FADE_LOG2 (FADE_LOG2)
  ) u_blend (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .comp_i  (comp_q),
    .go_i    (go_q),
    .alpha_i (blend_alpha_q),
    .blank_i (blank),
    .pixel_o (pixel_w)
  );

  assign bus.pixel_out  = pixel_w;
  assign bus.hcount_out = hcount_out_q;
  assign bus.vcount_out = vcount_out_q;
  assign bus.mode_out   = mode_q;

endmodule
